// File: rtl/transpose_col_serializer.sv
// transpose_col_serializer: holds one transpose-buffer column and streams its words with row/col tags
module transpose_col_serializer #(
    parameter int DATA_W = 12,
    parameter int N      = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    col_valid,
    output logic                    col_ready,
    input  logic [N*DATA_W-1:0]     col_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [$clog2(N)-1:0]    out_row,
    output logic [$clog2(N)-1:0]    out_col,
    output logic                    out_first,
    output logic                    out_last,
    output logic                    block_done
);
    localparam int RW = $clog2(N);

    typedef enum logic {EMPTY, HOLD} state_t;

    state_t                  state;
    logic [N-1:0][DATA_W-1:0] held;
    logic [RW-1:0]           row;
    logic [RW-1:0]           col;
    logic                    word_acc;
    logic                    last_row;
    logic                    col_acc;

    // handshakes; a new column may be taken in the same cycle the last row leaves
    always_comb begin
        out_valid = state == HOLD;
        word_acc  = out_valid & out_ready;
        last_row  = row == RW'(N - 1);
        col_ready = (state == EMPTY) | (word_acc & last_row);
        col_acc   = col_valid & col_ready;
        out_data  = held[row];
        out_row   = row;
        out_col   = col;
        out_first = out_valid & (row == '0) & (col == '0);
        out_last  = out_valid & last_row & (col == RW'(N - 1));
    end

    // column load, row/col walk and block-end pulse; row wraps to 0 naturally since N is a power of 2
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= EMPTY;
            held       <= '0;
            row        <= '0;
            col        <= '0;
            block_done <= 1'b0;
        end else begin
            block_done <= out_last & out_ready;
            if (word_acc & last_row)
                col <= col + 1'b1;
            if (col_acc) begin
                held  <= col_data;
                row   <= '0;
                state <= HOLD;
            end else if (word_acc) begin
                row   <= row + 1'b1;
                state <= last_row ? EMPTY : HOLD;
            end
        end
    end
endmodule

// File: tb/tb_transpose_col_serializer.sv
// tb_transpose_col_serializer: directed scenario checks for the column serializer
module tb_transpose_col_serializer;
    localparam int DATA_W = 12;
    localparam int N      = 8;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                col_valid = 1'b0;
    logic                col_ready;
    logic [N*DATA_W-1:0] col_data = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [DATA_W-1:0]   out_data;
    logic [2:0]          out_row;
    logic [2:0]          out_col;
    logic                out_first;
    logic                out_last;
    logic                block_done;

    int tests = 0;
    int fails = 0;

    transpose_col_serializer #(.DATA_W(DATA_W), .N(N)) dut (
        .clk(clk), .reset(reset), .col_valid(col_valid), .col_ready(col_ready),
        .col_data(col_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_row(out_row), .out_col(out_col),
        .out_first(out_first), .out_last(out_last), .block_done(block_done)
    );

    always #5 clk = ~clk;

    // word of source column sc (running count), row r; block 0 gives c*16+r
    function automatic logic [DATA_W-1:0] word_of(int sc, int r);
        return DATA_W'((sc / 8) * 'h900 + (sc % 8) * 16 + r);
    endfunction

    function automatic logic [N*DATA_W-1:0] mk_col(int sc);
        logic [N*DATA_W-1:0] v;
        for (int k = 0; k < N; k++) v[k*DATA_W +: DATA_W] = word_of(sc, k);
        return v;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        col_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        tests++; if (col_ready !== 1'b1) begin fails++; $display("FAIL reset col_ready got %b want 1", col_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset out_valid got %b want 0", out_valid); end
        tests++; if (out_data !== 12'h000) begin fails++; $display("FAIL reset out_data got %h want 000", out_data); end
        tests++; if (out_row !== 3'd0) begin fails++; $display("FAIL reset out_row got %0d want 0", out_row); end
        tests++; if (out_col !== 3'd0) begin fails++; $display("FAIL reset out_col got %0d want 0", out_col); end
        tests++; if (out_first !== 1'b0) begin fails++; $display("FAIL reset out_first got %b want 0", out_first); end
        tests++; if (out_last !== 1'b0) begin fails++; $display("FAIL reset out_last got %b want 0", out_last); end
        tests++; if (block_done !== 1'b0) begin fails++; $display("FAIL reset block_done got %b want 0", block_done); end
    endtask

    task automatic test_stream();
        int sc = 0;
        bit acc;
        do_reset();
        out_ready = 1'b1;
        for (int cyc = 0; cyc <= 66; cyc++) begin
            col_valid = sc < 8;
            col_data = mk_col(sc);
            #1;
            tests++;
            if (out_valid !== (cyc >= 1 && cyc <= 64)) begin
                fails++; $display("FAIL stream out_valid cyc %0d got %b", cyc, out_valid);
            end
            if (cyc >= 1 && cyc <= 64) begin
                int e;
                e = cyc - 1;
                tests++;
                if ({out_data, out_row, out_col, out_first, out_last} !==
                    {word_of(e / 8, e % 8), 3'(e % 8), 3'(e / 8), e == 0, e == 63}) begin
                    fails++; $display("FAIL stream word %0d got d=%h r=%0d c=%0d f=%b l=%b want d=%h", e,
                        out_data, out_row, out_col, out_first, out_last, word_of(e / 8, e % 8));
                end
            end
            tests++;
            if (block_done !== (cyc == 65)) begin
                fails++; $display("FAIL stream block_done cyc %0d got %b", cyc, block_done);
            end
            acc = col_valid && col_ready;
            @(posedge clk); #1;
            if (acc) sc++;
        end
        col_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        int sc = 0, e = 0, stall = 0, stalls = 0;
        bit done_stall = 0, acc;
        do_reset();
        for (int cyc = 0; cyc < 200 && e < 64; cyc++) begin
            if (!done_stall && out_valid && out_row == 3'd4 && out_col == 3'd2) begin
                stall = 3; done_stall = 1;
            end
            out_ready = stall == 0;
            col_valid = sc < 8;
            col_data = mk_col(sc);
            #1;
            if (stall > 0) begin
                tests++; stalls++;
                if ({out_data, out_row, out_col, out_valid, col_ready} !== {12'h024, 3'd4, 3'd2, 1'b1, 1'b0}) begin
                    fails++; $display("FAIL backpressure hold got d=%h r=%0d c=%0d v=%b cr=%b want d=024 r=4 c=2 v=1 cr=0",
                        out_data, out_row, out_col, out_valid, col_ready);
                end
                stall--;
            end
            if (out_valid && out_ready) begin
                tests++;
                if ({out_data, out_row, out_col} !== {word_of(e / 8, e % 8), 3'(e % 8), 3'(e / 8)}) begin
                    fails++; $display("FAIL backpressure word %0d got d=%h r=%0d c=%0d want d=%h", e,
                        out_data, out_row, out_col, word_of(e / 8, e % 8));
                end
                e++;
            end
            acc = col_valid && col_ready;
            @(posedge clk); #1;
            if (acc) sc++;
        end
        tests++; if (e !== 64) begin fails++; $display("FAIL backpressure words got %0d want 64", e); end
        tests++; if (stalls !== 3) begin fails++; $display("FAIL backpressure stall cycles got %0d want 3", stalls); end
        col_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        int sc = 0;
        bit acc;
        do_reset();
        out_ready = 1'b1;
        col_valid = 1'b1;
        for (int cyc = 0; cyc <= 70; cyc++) begin
            col_data = mk_col(sc);
            #1;
            tests++;
            if (col_ready !== (cyc % 8 == 0)) begin
                fails++; $display("FAIL b2b col_ready cyc %0d got %b want %b", cyc, col_ready, cyc % 8 == 0);
            end
            tests++;
            if (out_valid !== (cyc >= 1)) begin
                fails++; $display("FAIL b2b out_valid cyc %0d got %b", cyc, out_valid);
            end
            if (cyc >= 1) begin
                int e;
                e = cyc - 1;
                tests++;
                if ({out_data, out_row, out_col} !== {word_of(e / 8, e % 8), 3'(e % 8), 3'((e / 8) % 8)}) begin
                    fails++; $display("FAIL b2b word %0d got d=%h r=%0d c=%0d want d=%h", e,
                        out_data, out_row, out_col, word_of(e / 8, e % 8));
                end
            end
            acc = col_valid && col_ready;
            @(posedge clk); #1;
            if (acc) sc++;
        end
        col_valid = 1'b0;
    endtask

    task automatic test_starved();
        do_reset();
        out_ready = 1'b1;
        for (int cyc = 0; cyc <= 105; cyc++) begin
            int ph;
            ph = cyc % 13;
            col_valid = ph == 0 && cyc < 104;
            col_data = mk_col(cyc / 13);
            #1;
            tests++;
            if (out_valid !== (cyc < 104 && ph >= 1 && ph <= 8)) begin
                fails++; $display("FAIL starved out_valid cyc %0d got %b", cyc, out_valid);
            end
            if (cyc < 104 && ph >= 1 && ph <= 8) begin
                tests++;
                if ({out_data, out_row, out_col} !== {word_of(cyc / 13, ph - 1), 3'(ph - 1), 3'(cyc / 13)}) begin
                    fails++; $display("FAIL starved word cyc %0d got d=%h r=%0d c=%0d want d=%h r=%0d c=%0d", cyc,
                        out_data, out_row, out_col, word_of(cyc / 13, ph - 1), ph - 1, cyc / 13);
                end
            end
            @(posedge clk); #1;
        end
        col_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        int sc = 0;
        bit found = 0, acc;
        do_reset();
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 100 && !found; cyc++) begin
            if (out_valid && out_row == 3'd3 && out_col == 3'd5) begin
                found = 1;
            end else begin
                col_valid = sc < 8;
                col_data = mk_col(sc);
                #1;
                acc = col_valid && col_ready;
                @(posedge clk); #1;
                if (acc) sc++;
            end
        end
        tests++; if (found !== 1'b1) begin fails++; $display("FAIL reset_mid never reached row 3 col 5"); end
        reset = 1'b1;
        col_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        tests++;
        if ({out_valid, col_ready, out_row, out_col, block_done} !== {1'b0, 1'b1, 3'd0, 3'd0, 1'b0}) begin
            fails++; $display("FAIL reset_mid after reset got v=%b cr=%b r=%0d c=%0d bd=%b want v=0 cr=1 r=0 c=0 bd=0",
                out_valid, col_ready, out_row, out_col, block_done);
        end
        col_valid = 1'b1;
        col_data = mk_col(20);
        @(posedge clk); #1;
        col_valid = 1'b0;
        #1;
        tests++;
        if ({out_valid, out_row, out_col, out_first, out_data} !== {1'b1, 3'd0, 3'd0, 1'b1, word_of(20, 0)}) begin
            fails++; $display("FAIL reset_mid restart got v=%b r=%0d c=%0d f=%b d=%h want v=1 r=0 c=0 f=1 d=%h",
                out_valid, out_row, out_col, out_first, out_data, word_of(20, 0));
        end
    endtask

    task automatic test_random();
        int sc = 0, e = 0, dones = 0, lasts = 0, post = 0;
        bit acc;
        void'($urandom(32'd12345));
        do_reset();
        for (int cyc = 0; cyc < 3000 && post < 2; cyc++) begin
            if (!col_valid && sc < 16) col_valid = $urandom_range(0, 3) != 0;
            col_data = mk_col(sc);
            out_ready = $urandom_range(0, 3) != 0;
            #1;
            if (block_done) dones++;
            if (out_valid && out_ready) begin
                tests++;
                if ({out_data, out_row, out_col, out_first, out_last} !==
                    {word_of(e / 8, e % 8), 3'(e % 8), 3'((e / 8) % 8), e % 64 == 0, e % 64 == 63}) begin
                    fails++; $display("FAIL random word %0d got d=%h r=%0d c=%0d f=%b l=%b want d=%h", e,
                        out_data, out_row, out_col, out_first, out_last, word_of(e / 8, e % 8));
                end
                if (out_last) lasts++;
                e++;
            end
            acc = col_valid && col_ready;
            @(posedge clk); #1;
            if (acc) begin sc++; col_valid = 1'b0; end
            if (e >= 128) post++;
        end
        tests++; if (e !== 128) begin fails++; $display("FAIL random words got %0d want 128", e); end
        tests++; if (dones !== 2) begin fails++; $display("FAIL random block_done pulses got %0d want 2", dones); end
        tests++; if (lasts !== 2) begin fails++; $display("FAIL random out_last count got %0d want 2", lasts); end
        col_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_back_to_back();
        test_starved();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
